// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch PC sequencer with request/stall handshake and jump/branch redirect
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        instr_valid,
    output logic [31:0] fetch_pc
);
    typedef enum logic [1:0] {IDLE, REQ, STALL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        accept, redirect;
    logic [31:0] target;

    // next-state, next-pc and fetch bookkeeping; redirects are only honoured outside IDLE
    always_comb begin
        imem_req      = (state_q == REQ) && !stall;
        accept        = imem_req && imem_ready;
        redirect      = (state_q != IDLE) && (jump || branch_taken);
        target        = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
        pc4           = pc_q + 32'd4;
        pc_d          = redirect ? target : (accept ? pc4 : pc_q);
        fetch_pc_d    = accept ? pc_q : fetch_pc_q;
        instr_valid_d = accept;
        state_d       = (state_q == IDLE) ? REQ : (stall ? STALL : REQ);
    end

    // state registers with synchronous active-low reset overriding everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_pc    = fetch_pc_q;
    assign instr_valid = instr_valid_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, stall, jump, branch_taken, imem_ready;
    logic [31:0] jump_target, branch_target;
    logic        imem_req, instr_valid;
    logic [31:0] pc, pc4, fetch_pc;
    int          tests = 0;
    int          fails = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem_ready(imem_ready),
        .imem_req(imem_req), .pc(pc), .pc4(pc4), .instr_valid(instr_valid), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] efpc,
                             input logic ev, input logic ereq);
        chk({tag, "_pc"}, pc, epc);
        chk({tag, "_fetch_pc"}, fetch_pc, efpc);
        chk({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, ev});
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, ereq});
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
        jump_target = 32'h0; branch_target = 32'h0;
        cyc(); cyc();
        chk_state("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 chk_state("idle", 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk_state("first_req", 32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk_state("seq", 32'(4 * k), 32'(4 * (k - 1)), 1'b1, 1'b1);
            chk("seq_pc4", pc4, 32'(4 * k + 4));
        end
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_state("wait", 32'h10, 32'hC, 1'b0, 1'b1);
        end
        imem_ready = 1'b1;
        cyc();
        chk_state("wait_done", 32'h14, 32'h10, 1'b1, 1'b1);
        imem_ready = 1'b0;
        cyc();
        chk_state("one_pulse", 32'h14, 32'h10, 1'b0, 1'b1);
        imem_ready = 1'b1;
        for (int k = 0; k < 11; k++) cyc();
        chk_state("at_40", 32'h40, 32'h3C, 1'b1, 1'b1);
        jump = 1'b1; jump_target = 32'h0040_0100; branch_taken = 1'b1; branch_target = 32'h0000_0999;
        cyc();
        chk_state("jump_wins", 32'h0040_0100, 32'h40, 1'b1, 1'b1);
        jump = 1'b0; branch_taken = 1'b0;
        stall = 1'b1;
        #1 chk("stall_req_comb", {31'd0, imem_req}, 32'd0);
        cyc();
        chk_state("stall1", 32'h0040_0100, 32'h40, 1'b0, 1'b0);
        branch_taken = 1'b1; branch_target = 32'h0000_0203;
        cyc();
        chk_state("stall2_branch", 32'h200, 32'h40, 1'b0, 1'b0);
        branch_taken = 1'b0; stall = 1'b0;
        #1 chk("stall_exit_req", {31'd0, imem_req}, 32'd0);
        cyc();
        chk_state("resume", 32'h200, 32'h40, 1'b0, 1'b1);
        cyc();
        chk_state("resume_fetch", 32'h204, 32'h200, 1'b1, 1'b1);
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        cyc();
        chk_state("to_top", 32'hFFFF_FFFC, 32'h204, 1'b1, 1'b1);
        chk("wrap_pc4", pc4, 32'h0);
        jump = 1'b0;
        cyc();
        chk_state("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b1);
        chk("wrap_pc4_after", pc4, 32'h4);
        jump = 1'b1; jump_target = 32'h0000_0080;
        cyc();
        chk_state("at_80", 32'h80, 32'h0, 1'b1, 1'b1);
        jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0300;
        reset = 1'b0;
        cyc();
        chk_state("reset_mid", 32'h0, 32'h0, 1'b0, 1'b0);
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h0000_0500;
        reset = 1'b1;
        cyc();
        chk_state("idle_ignores_jump", 32'h0, 32'h0, 1'b0, 1'b1);
        jump = 1'b0;
        cyc();
        chk_state("post_reset_fetch", 32'h4, 32'h0, 1'b1, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, is the synchronous active-low reset.
REQ-004 Port stall, input, 1, holds fetch while high.
REQ-005 Port jump, input, 1, marks a jump redirect in the current cycle.
REQ-006 Port jump_target, input, 32, is the jump address from the jump-address stage ({PC4[31:28], instr[25:0], 2'b00}).
REQ-007 Port branch_taken, input, 1, marks a taken-branch redirect in the current cycle.
REQ-008 Port branch_target, input, 32, is the branch address.
REQ-009 Port imem_ready, input, 1, is the instruction-memory acceptance of a request.
REQ-010 Port imem_req, output, 1, is the fetch request, combinational from state and stall.
REQ-011 Port pc, output, 32, is the current fetch address, registered.
REQ-012 Port pc4, output, 32, is pc+4, combinational; it feeds the jump-address stage.
REQ-013 Port instr_valid, output, 1, is a registered one-cycle pulse after each accepted fetch.
REQ-014 Port fetch_pc, output, 32, is the registered address of the most recently accepted fetch.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ, STALL; encoding is free.
REQ-016 IDLE SHALL last exactly one cycle after reset deasserts, then go to REQ unconditionally.
REQ-017 imem_req SHALL be 1 only when state==REQ and stall==0.
REQ-018 Accept SHALL be defined as imem_req && imem_ready at a rising edge.
REQ-019 On accept: fetch_pc <= pc; instr_valid <= 1 for exactly the next cycle; pc <= next_pc.
REQ-020 next_pc priority SHALL be: jump -> jump_target, else branch_taken -> branch_target, else pc4.
REQ-021 Redirect without accept (state REQ or STALL, jump or branch_taken high) SHALL load pc with the target per REQ-020; instr_valid SHALL stay 0.
REQ-022 Redirect inputs SHALL be ignored in IDLE.
REQ-023 Both target inputs SHALL be loaded with bits [1:0] forced to 2'b00.
REQ-024 pc4 SHALL wrap modulo 2^32: pc=32'hFFFF_FFFC gives pc4=32'h0000_0000.
REQ-025 REQ with stall==1 SHALL go to STALL and issue no request that cycle.
REQ-026 STALL with stall==0 SHALL return to REQ; otherwise it SHALL stay in STALL.
REQ-027 In REQ with no accept and no redirect, pc SHALL hold and imem_req SHALL stay high (request held until accepted).
REQ-028 instr_valid SHALL be 0 in every cycle not immediately following an accept.

Reset
REQ-029 reset==0 at a rising edge SHALL set: pc=RESET_PC, fetch_pc=RESET_PC, instr_valid=0, state=IDLE (so imem_req=0).
REQ-030 Reset SHALL override accept, redirect and stall in the same cycle, including mid-request; no instr_valid pulse SHALL follow.

Verification
REQ-031 Reset release, imem_ready=1 constant -> one IDLE cycle, then pc = 0, 4, 8, ...; instr_valid high each cycle with fetch_pc lagging pc by 4.
REQ-032 At pc=0x40, jump=1, jump_target=0x0040_0100, branch_taken=1 with accept -> pc=0x0040_0100, fetch_pc=0x40 (jump wins).
REQ-033 imem_ready=0 for 3 cycles at pc=0x10 -> imem_req held high, pc=0x10, no instr_valid; ready=1 -> pc=0x14 with one valid pulse.
REQ-034 stall=1 for 2 cycles in REQ, with branch_taken=1 and branch_target=0x203 in the second -> imem_req=0; pc=0x200; fetch resumes at 0x200 after stall drops.
REQ-035 pc=0xFFFF_FFFC accepted -> pc=0x0000_0000, pc4=0x4.
REQ-036 reset=0 asserted in the same cycle as an accept at pc=0x80 -> pc=RESET_PC, instr_valid=0 on the next cycle, state IDLE.
